// File: rtl/instr_encode_loader.sv
// Encodes R/I-type operation requests into 32-bit MIPS words and streams them
// through a small FIFO into instruction memory. Optional macro: ENC_ILLEGAL_TRAP_EN.
module instr_encode_loader #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_type,
    input  logic [2:0]        req_aop,
    input  logic [4:0]        req_rs,
    input  logic [4:0]        req_rt,
    input  logic [4:0]        req_rd,
    input  logic [15:0]       req_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [15:0]       word_cnt,
    output logic              err_illegal
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              enc_valid_q, enc_valid_d;
    logic [31:0]       enc_word_q, enc_word_d;
    logic [31:0]       fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [31:0]       last_word_q, last_word_d;
    logic [5:0]        funct, imm_op;
    logic [31:0]       req_word;
    logic              accept, push, pop, fifo_empty, drop_req;

    always_comb begin
        funct  = 6'b000100;
        imm_op = 6'b001000;
        case (req_aop)
            3'b100: begin funct = 6'b100000; imm_op = 6'b001000; end
            3'b101:       funct = 6'b100010;
            3'b000: begin funct = 6'b100100; imm_op = 6'b001100; end
            3'b001:       funct = 6'b100101;
            3'b010: begin funct = 6'b100110; imm_op = 6'b001110; end
            3'b011:       funct = 6'b100111;
            3'b110: begin funct = 6'b101011; imm_op = 6'b001011; end
            default:      funct = 6'b000100;
        endcase
        case (req_type)
            2'd0:    req_word = {6'b000000, req_rs, req_rt, req_rd, 5'b00000, funct};
            2'd1:    req_word = {imm_op, req_rs, req_rt, req_imm};
            2'd2:    req_word = {6'b100011, req_rs, req_rt, req_imm};
            default: req_word = {6'b101011, req_rs, req_rt, req_imm};
        endcase
    end

    // The encode stage counts toward capacity, so a full pipe never overruns the FIFO.
    assign fifo_empty = (count_q == '0);
    assign req_ready  = !clr && ((count_q + CNT_W'(enc_valid_q)) < CNT_W'(DEPTH));
    assign accept     = req_valid && req_ready;
    assign push       = enc_valid_q;
    assign pop        = !fifo_empty && imem_ready;

`ifdef ENC_ILLEGAL_TRAP_EN
    logic err_q, err_d;
    assign drop_req = accept && (req_type == 2'd1) &&
                      !(req_aop == 3'b100 || req_aop == 3'b000 ||
                        req_aop == 3'b010 || req_aop == 3'b110);
    assign err_d       = clr ? 1'b0 : (err_q | drop_req);
    assign err_illegal = err_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end
`else
    assign drop_req    = 1'b0;
    assign err_illegal = 1'b0;
`endif

    always_comb begin
        enc_valid_d = accept && !drop_req;
        enc_word_d  = accept ? req_word : enc_word_q;
        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        addr_d      = pop ? addr_q + 1'b1 : addr_q;
        word_cnt_d  = pop ? word_cnt_q + 16'd1 : word_cnt_q;
        last_word_d = pop ? fifo_mem_q[rd_ptr_q] : last_word_q;
        if (clr) begin
            enc_valid_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            addr_d      = BASE_ADDR;
            word_cnt_d  = '0;
            last_word_d = last_word_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_valid_q <= 1'b0;
            enc_word_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            addr_q      <= BASE_ADDR;
            word_cnt_q  <= '0;
            last_word_q <= '0;
        end else begin
            enc_valid_q <= enc_valid_d;
            enc_word_q  <= enc_word_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            addr_q      <= addr_d;
            word_cnt_q  <= word_cnt_d;
            last_word_q <= last_word_d;
        end
    end

    // Storage needs no reset: occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !clr) fifo_mem_q[wr_ptr_q] <= enc_word_q;
    end

    assign imem_we    = !fifo_empty;
    assign imem_addr  = addr_q;
    assign imem_wdata = fifo_empty ? last_word_q : fifo_mem_q[rd_ptr_q];
    assign word_cnt   = word_cnt_q;
endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader: table-driven reference encoder feeds
// an expected-word queue, a monitor checks every memory write. Honors ENC_ILLEGAL_TRAP_EN.
module tb_instr_encode_loader;
    localparam int DEPTH = 4;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst_n, clr, req_valid, req_ready, imem_we, imem_ready, err_illegal;
    logic [1:0] req_type;
    logic [2:0] req_aop;
    logic [4:0] req_rs, req_rt, req_rd;
    logic [15:0] req_imm, word_cnt;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0] imem_wdata;

    instr_encode_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .req_type(req_type), .req_aop(req_aop), .req_rs(req_rs), .req_rt(req_rt),
        .req_rd(req_rd), .req_imm(req_imm), .imem_we(imem_we), .imem_ready(imem_ready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .word_cnt(word_cnt),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    // Reference tables indexed by ALU op code.
    localparam logic [5:0] R_FUNCT [8] = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h20, 6'h22, 6'h2B, 6'h04};
    localparam logic [5:0] I_OP    [8] = '{6'h0C, 6'h08, 6'h0E, 6'h08, 6'h08, 6'h08, 6'h0B, 6'h08};
    localparam logic [7:0] I_LEGAL = 8'b0101_0101;

    int checks = 0;
    int errors = 0;
    int writes = 0;
    logic [31:0] exp_q[$];
    logic [ADDR_W-1:0] m_addr = '0;
    logic [15:0] m_cnt = '0;
    logic stall_prev = 1'b0;
    logic [31:0] held_w;
    logic [ADDR_W-1:0] held_a;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [1:0] t, input logic [2:0] aop,
            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
        logic [31:0] w;
        if (t == 2'd0)      w = {6'd0, rs, rt, rd, 5'd0, R_FUNCT[aop]};
        else if (t == 2'd1) w = {I_OP[aop], rs, rt, imm};
        else if (t == 2'd2) w = {6'h23, rs, rt, imm};
        else                w = {6'h2B, rs, rt, imm};
        return w;
    endfunction

    function automatic logic is_illegal(input logic [1:0] t, input logic [2:0] aop);
        logic [7:0] legal;
        legal = I_LEGAL;
        return (t == 2'd1) && !legal[aop];
    endfunction

    // One cycle of stimulus: drive at negedge, record acceptance before the edge.
    task automatic step(input logic v, input logic [1:0] t, input logic [2:0] aop,
            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
            input logic [15:0] imm, input logic rdy, input logic c, output logic acc);
        @(negedge clk);
        req_valid = v; req_type = t; req_aop = aop; req_rs = rs; req_rt = rt;
        req_rd = rd; req_imm = imm; imem_ready = rdy; clr = c;
        #1;
        acc = v && req_ready;
        if (acc) begin
`ifdef ENC_ILLEGAL_TRAP_EN
            if (!is_illegal(t, aop)) exp_q.push_back(ref_word(t, aop, rs, rt, rd, imm));
`else
            exp_q.push_back(ref_word(t, aop, rs, rt, rd, imm));
`endif
        end
    endtask

    task automatic idle(input logic rdy);
        logic a;
        step(1'b0, 2'd0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, rdy, 1'b0, a);
    endtask

    task automatic rand_step(input logic v, input logic rdy, input logic c,
            input logic allow_ill, output logic acc);
        logic [1:0] t;
        logic [2:0] aop;
        t = 2'($urandom_range(0, 3));
        aop = 3'($urandom_range(0, 7));
        if (!allow_ill && is_illegal(t, aop)) aop = 3'b100;
        step(v, t, aop, 5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), rdy, c, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 1'b0; clr = 1'b0; imem_ready = 1'b0;
        #3;
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        chk("rst_err", 32'(err_illegal), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || imem_we) && n < 300) begin
            idle(1'b1);
            #2;
            n++;
        end
        chk("drain_timeout", 32'(n >= 300), 32'd0);
        chk("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compares each accepted memory write against the scoreboard.
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            exp_q.delete();
            m_addr = '0; m_cnt = '0; stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_we", 32'(imem_we), 32'd1);
                chk("hold_wdata", imem_wdata, held_w);
                chk("hold_addr", 32'(imem_addr), 32'(held_a));
            end
            if (imem_we && imem_ready && !clr) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", imem_wdata, 32'hxxxx_xxxx);
                end else begin
                    chk("wdata", imem_wdata, exp_q.pop_front());
                end
                chk("addr", 32'(imem_addr), 32'(m_addr));
                chk("cnt", 32'(word_cnt), 32'(m_cnt));
                m_addr = m_addr + 1'b1;
                m_cnt = m_cnt + 16'd1;
                writes++;
            end
            stall_prev = imem_we && !imem_ready && !clr;
            held_w = imem_wdata;
            held_a = imem_addr;
            if (clr) begin
                exp_q.delete();
                m_addr = '0; m_cnt = '0;
            end
        end
    end

    initial begin
        logic a;
        int acc_n, w0;
        rst_n = 1'b1; clr = 1'b0; req_valid = 1'b0; imem_ready = 1'b0;
        req_type = '0; req_aop = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
        do_reset();

        // R-type add: two-cycle latency to the write.
        step(1'b1, 2'd0, 3'b100, 5'd1, 5'd2, 5'd3, 16'd0, 1'b1, 1'b0, a);
        chk("add_acc", 32'(a), 32'd1);
        idle(1'b1);
        chk("lat_we_n1", 32'(imem_we), 32'd0);
        idle(1'b1);
        chk("lat_we_n2", 32'(imem_we), 32'd1);
        chk("add_word", imem_wdata, 32'h0022_1820);
        chk("add_addr", 32'(imem_addr), 32'd0);
        idle(1'b1);
        chk("add_cnt", 32'(word_cnt), 32'd1);
        chk("empty_hold", imem_wdata, 32'h0022_1820);

        // andi followed by load.
        do_reset();
        step(1'b1, 2'd1, 3'b000, 5'd4, 5'd5, 5'd0, 16'h00FF, 1'b1, 1'b0, a);
        step(1'b1, 2'd2, 3'b111, 5'd0, 5'd6, 5'd9, 16'd8, 1'b1, 1'b0, a);
        idle(1'b1);
        chk("andi_word", imem_wdata, 32'h3085_00FF);
        idle(1'b1);
        chk("lw_word", imem_wdata, 32'h8C06_0008);
        chk("lw_addr", 32'(imem_addr), 32'd1);
        drain();

        // Stores against a stalled memory: capacity then burst drain.
        do_reset();
        acc_n = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 2'd3, 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                 16'($urandom), 1'b0, 1'b0, a);
            if (a) acc_n++;
        end
        chk("full_accepts", 32'(acc_n), 32'(DEPTH));
        chk("full_ready", 32'(req_ready), 32'd0);
        chk("store_op", 32'(imem_wdata[31:26]), 32'h2B);
        w0 = writes;
        for (int i = 0; i < 4; i++) idle(1'b1);
        #2;
        chk("burst_writes", 32'(writes - w0), 32'd4);
        idle(1'b1);
        chk("burst_empty", 32'(imem_we), 32'd0);

        // 257 words: address wraps to 0, counter keeps going.
        do_reset();
        acc_n = 0;
        while (acc_n < 257) begin
            rand_step(1'b1, 1'b1, 1'b0, 1'b0, a);
            if (a) acc_n++;
        end
        drain();
        chk("wrap_cnt", 32'(word_cnt), 32'd257);
        chk("wrap_addr", 32'(imem_addr), 32'd1);

        // Illegal ALU-immediate op.
        do_reset();
        step(1'b1, 2'd1, 3'b001, 5'd7, 5'd8, 5'd0, 16'h1234, 1'b1, 1'b0, a);
        idle(1'b1);
        idle(1'b1);
`ifdef ENC_ILLEGAL_TRAP_EN
        chk("ill_err", 32'(err_illegal), 32'd1);
        chk("ill_we", 32'(imem_we), 32'd0);
        drain();
        chk("ill_cnt", 32'(word_cnt), 32'd0);
        step(1'b0, 2'd0, 3'd0, 5'd0, 5'd0, 5'd0, 16'd0, 1'b1, 1'b1, a);
        idle(1'b1);
        chk("ill_err_clr", 32'(err_illegal), 32'd0);
`else
        chk("ill_addi_op", 32'(imem_wdata[31:26]), 32'h08);
        drain();
        chk("ill_cnt", 32'(word_cnt), 32'd1);
        chk("ill_err", 32'(err_illegal), 32'd0);
`endif

        // clr with queued words after some writes.
        do_reset();
        for (int i = 0; i < 2; i++) rand_step(1'b1, 1'b1, 1'b0, 1'b0, a);
        for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b0, 1'b0, 1'b0, a);
        idle(1'b0);
        step(1'b1, 2'd2, 3'd0, 5'd1, 5'd1, 5'd1, 16'd1, 1'b1, 1'b1, a);
        chk("clr_ready", 32'(req_ready), 32'd0);
        idle(1'b1);
        chk("clr_we", 32'(imem_we), 32'd0);
        chk("clr_addr", 32'(imem_addr), 32'd0);
        chk("clr_cnt", 32'(word_cnt), 32'd0);

        // Asynchronous reset in the middle of a stream.
        for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b1, 1'b0, 1'b0, a);
        for (int i = 0; i < 3; i++) rand_step(1'b1, 1'b0, 1'b0, 1'b0, a);
        do_reset();
        idle(1'b1);
        chk("rstmid_we", 32'(imem_we), 32'd0);

        // Random traffic with back-pressure and occasional clr.
        for (int i = 0; i < 2000; i++) begin
            rand_step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                      ($urandom_range(0, 199) == 0), 1'b1, a);
        end
        drain();
        chk("final_cnt", 32'(word_cnt), 32'(m_cnt));
`ifndef ENC_ILLEGAL_TRAP_EN
        chk("final_err", 32'(err_illegal), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Inverse of the R/I-type control decoder: converts an operation request (class, ALU op code, register fields, immediate) into a 32-bit MIPS instruction word.
- Queues encoded words in a small FIFO and streams them into instruction memory at consecutive word addresses.
- Sits between the test/boot sequencer and the instruction memory write port of the R/I CPU.

Parameters:
- DEPTH, 4, FIFO entries, counting the encode stage; power of two, minimum 2.
- ADDR_W, 8, width of the instruction-memory word address.
- BASE_ADDR, 0, first word address written after reset or clr.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush; restart at BASE_ADDR.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid and req_ready are both high at a rising edge.
- req_type  in  2  request class: 0=R-type, 1=ALU-immediate, 2=load, 3=store.
- req_aop  in  3  ALU op code, same encoding the decoder emits on aop.
- req_rs  in  5  rs field.
- req_rt  in  5  rt field.
- req_rd  in  5  rd field (R-type only).
- req_imm  in  16  immediate (I-type only).
- imem_we  out  1  word valid toward instruction memory.
- imem_ready  in  1  memory accepts the word.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- word_cnt  out  16  number of words written; wraps at 16 bits.
- err_illegal  out  1  sticky illegal-request flag.

Behaviour:
- Reset (rst_n low, asynchronous): FIFO and encode stage empty; imem_we=0; imem_addr=BASE_ADDR; imem_wdata=0; word_cnt=0; err_illegal=0; req_ready=1.
  - Reset mid-stream discards all queued words.
- R-type encoding: {6'b000000, rs, rt, rd, 5'b0, funct}. req_aop to funct:
  - 100 -> 100000
  - 101 -> 100010
  - 000 -> 100100
  - 001 -> 100101
  - 010 -> 100110
  - 011 -> 100111
  - 110 -> 101011
  - 111 -> 000100
- ALU-immediate encoding: {op, rs, rt, imm}. req_aop to op:
  - 100 -> 001000
  - 000 -> 001100
  - 010 -> 001110
  - 110 -> 001011
  - Any other aop is illegal.
- Load: op=100011. Store: op=101011. For both, req_aop and req_rd are ignored.
- Pipeline:
  - Request accepted at edge N is registered in the encode stage.
  - It moves into the FIFO at edge N+1.
  - If the FIFO was empty, imem_we is high in the cycle after edge N+1.
  - Minimum accept-to-write latency is 2 cycles; sustained throughput is 1 word per cycle.
- req_ready = (FIFO entries + encode-stage valid) < DEPTH.
  - When full, req_ready=0.
  - Accept and drain in the same cycle are allowed; occupancy stays unchanged.
- Output handshake:
  - imem_we = FIFO not empty.
  - imem_addr and imem_wdata reflect the FIFO head and stay stable while imem_we=1 and imem_ready=0.
  - On imem_we & imem_ready: pop the head, increment imem_addr modulo 2^ADDR_W (wraps from all-ones to 0, not to BASE_ADDR), increment word_cnt.
- clr (synchronous, highest priority):
  - Flushes FIFO and encode stage; imem_addr=BASE_ADDR; word_cnt=0; err_illegal=0.
  - A request presented with clr is not accepted; req_ready is forced 0 during clr.
  - A pending imem write in that cycle is not counted.
- Empty FIFO: imem_we=0; imem_wdata holds its last value.

Optional Feature:
- Macro: ENC_ILLEGAL_TRAP_EN.
- Defined: an illegal ALU-immediate request is accepted, consumes no FIFO entry, is dropped, and sets err_illegal (sticky until reset or clr).
- Undefined: an illegal ALU-immediate request is encoded as addi (op 001000), matching the decoder's default path; err_illegal is tied 0.

Test Plan:
- Reset, then R-type add (aop=100, rs=1, rt=2, rd=3), imem_ready=1 -> after 2 cycles imem_we=1, imem_addr=0, imem_wdata=0x00221820, word_cnt becomes 1.
- ALU-immediate andi (aop=000, rs=4, rt=5, imm=0x00FF), then load (rs=0, rt=6, imm=8) -> imem_wdata 0x308500FF at address 0, then 0x8C060008 at address 1.
- Store with imem_ready=0 for 5 cycles while issuing requests -> req_ready drops after DEPTH=4 accepted; head 0xAC... held stable; after imem_ready=1, all 4 words written in 4 consecutive cycles.
- ADDR_W=8, stream 257 words -> addresses 0..255 then 0; word_cnt=257.
- ALU-immediate aop=001 -> with ENC_ILLEGAL_TRAP_EN: no write, err_illegal=1. Without the macro: word 0x2000_xxxx (addi) is written.
- 3 words queued, assert clr for 1 cycle -> imem_we=0 next cycle, imem_addr=BASE_ADDR, word_cnt=0; an async rst_n pulse mid-stream gives the same result.
